// File: rtl/cache_line_refill.sv
// Cache-miss refill engine: one burst read per miss, beats assembled into a line, single-cycle data-array write.
// Optional critical-word forwarding is built only when REFILL_FWD_EN is defined.
module cache_line_refill #(
    parameter int LINE_WIDTH  = 256,
    parameter int WORD_WIDTH  = 32,
    parameter int INDEX_WIDTH = 3,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    output logic                   mem_rd_req_valid,
    input  logic                   mem_rd_req_ready,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
    output logic [7:0]             mem_rd_len,
    input  logic                   mem_rdata_valid,
    output logic                   mem_rdata_ready,
    input  logic [WORD_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_rdata_last,
    output logic [INDEX_WIDTH-1:0] da_waddr,
    output logic                   da_wen,
    output logic [LINE_WIDTH-1:0]  da_wdata,
    output logic                   done,
    output logic                   err,
    output logic                   fwd_valid,
    output logic [WORD_WIDTH-1:0]  fwd_data
);

    localparam int BEATS = LINE_WIDTH / WORD_WIDTH;
    localparam int OFF   = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   req_ready_q;
    logic                   mem_rd_req_valid_q;
    logic                   mem_rdata_ready_q;
    logic                   da_wen_q;
    logic                   done_q;
    logic                   err_q;
    logic [INDEX_WIDTH-1:0] da_waddr_q;
    logic [ADDR_WIDTH-1:0]  mem_rd_addr_q;
    logic [LINE_WIDTH-1:0]  line_q;
    logic                   beat;
    logic                   unused_addr_bits;

    assign beat             = mem_rdata_valid && mem_rdata_ready_q;
    assign unused_addr_bits = ^req_addr[OFF-1:0];

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values and evaluation order inside the block cannot matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= S_IDLE;
            cnt_q              <= '0;
            req_ready_q        <= 1'b1;
            mem_rd_req_valid_q <= 1'b0;
            mem_rdata_ready_q  <= 1'b0;
            da_wen_q           <= 1'b0;
            done_q             <= 1'b0;
            err_q              <= 1'b0;
            da_waddr_q         <= '0;
            mem_rd_addr_q      <= '0;
        end else begin
            da_wen_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        state_q            <= S_REQ;
                        req_ready_q        <= 1'b0;
                        mem_rd_req_valid_q <= 1'b1;
                        mem_rd_addr_q      <= {req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                        err_q              <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_rd_req_ready) begin
                        state_q            <= S_RECV;
                        mem_rd_req_valid_q <= 1'b0;
                        mem_rdata_ready_q  <= 1'b1;
                        cnt_q              <= '0;
                    end
                end
                S_RECV: begin
                    if (beat) begin
                        // Only the beat count ends the burst; a misplaced last just flags err.
                        if (mem_rdata_last != (cnt_q == LAST_CNT)) begin
                            err_q <= 1'b1;
                        end
                        if (cnt_q == LAST_CNT) begin
                            state_q           <= S_WRITE;
                            mem_rdata_ready_q <= 1'b0;
                            da_wen_q          <= 1'b1;
                            da_waddr_q        <= mem_rd_addr_q[OFF+INDEX_WIDTH-1:OFF];
                            cnt_q             <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the line buffer is pure datapath and is deliberately left out of reset;
    // every slot is overwritten by a beat before the array write can consume it.
    always_ff @(posedge clk) begin
        if (beat) begin
            line_q[WORD_WIDTH*cnt_q +: WORD_WIDTH] <= mem_rdata;
        end
    end

`ifdef REFILL_FWD_EN
    logic [CNT_W-1:0]      word_sel_q;
    logic                  fwd_valid_q;
    logic [WORD_WIDTH-1:0] fwd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_sel_q  <= '0;
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            if (state_q == S_IDLE && req_valid) begin
                word_sel_q <= req_addr[OFF-1:2];
            end
            fwd_valid_q <= beat && (cnt_q == word_sel_q);
            if (beat && (cnt_q == word_sel_q)) begin
                fwd_data_q <= mem_rdata;
            end
        end
    end

    assign fwd_valid = fwd_valid_q;
    assign fwd_data  = fwd_data_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_data  = '0;
`endif

    assign req_ready        = req_ready_q;
    assign mem_rd_req_valid = mem_rd_req_valid_q;
    assign mem_rd_addr      = mem_rd_addr_q;
    assign mem_rd_len       = 8'(BEATS - 1);
    assign mem_rdata_ready  = mem_rdata_ready_q;
    assign da_waddr         = da_waddr_q;
    assign da_wen           = da_wen_q;
    assign da_wdata         = line_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_cache_line_refill.sv
// Directed bench for cache_line_refill: idle state, clean refill, stalled refill,
// misplaced last, mid-refill reset and forwarding (checked per REFILL_FWD_EN).
module tb_cache_line_refill;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         mem_rd_req_valid;
    logic         mem_rd_req_ready;
    logic [31:0]  mem_rd_addr;
    logic [7:0]   mem_rd_len;
    logic         mem_rdata_valid;
    logic         mem_rdata_ready;
    logic [31:0]  mem_rdata;
    logic         mem_rdata_last;
    logic [2:0]   da_waddr;
    logic         da_wen;
    logic [255:0] da_wdata;
    logic         done;
    logic         err;
    logic         fwd_valid;
    logic [31:0]  fwd_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cache_line_refill dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .mem_rd_req_valid (mem_rd_req_valid),
        .mem_rd_req_ready (mem_rd_req_ready),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_len       (mem_rd_len),
        .mem_rdata_valid  (mem_rdata_valid),
        .mem_rdata_ready  (mem_rdata_ready),
        .mem_rdata        (mem_rdata),
        .mem_rdata_last   (mem_rdata_last),
        .da_waddr         (da_waddr),
        .da_wen           (da_wen),
        .da_wdata         (da_wdata),
        .done             (done),
        .err              (err),
        .fwd_valid        (fwd_valid),
        .fwd_data         (fwd_data)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle c counts from the accepting edge (c=1 is the first REQ cycle).
    // exp_end is the da_wen cycle for a normal run, or the first IDLE cycle after a reset.
    task automatic run_refill(input string nm, input logic [31:0] addr, input logic [31:0] base,
                              input int req_stall, input bit gap, input int last_idx,
                              input int rst_beat, input int exp_end, input logic [2:0] exp_idx,
                              input logic [31:0] exp_maddr, input bit exp_err, input int exp_fwd);
        int           b = 0;
        int           wen_n = 0;
        int           wen_c = -1;
        int           done_c = -1;
        int           fwd_n = 0;
        int           fwd_c = -1;
        int           back_c = -1;
        bit           did_rst = 1'b0;
        logic         rdy_after_rst = 1'b0;
        logic         mrdy_after_rst = 1'b1;
        logic [255:0] line = '0;
        logic [255:0] exp_line;
        logic [2:0]   waddr = '0;
        logic         err_wen = 1'b0;
        logic         err_done = 1'b0;
        logic [31:0]  fwd_d = '0;
        logic [2:0]   wsel;

        @(negedge clk);
        check({nm, ":req_ready_idle"}, 256'(req_ready), 256'(1));
        req_valid = 1'b1;
        req_addr  = addr;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (did_rst) begin
                rst            = 1'b0;
                rdy_after_rst  = req_ready;
                mrdy_after_rst = mem_rdata_ready;
                back_c         = c;
                break;
            end
            if (c == 1) begin
                check({nm, ":req_valid_out"}, 256'(mem_rd_req_valid), 256'(1));
                check({nm, ":rd_addr"}, 256'(mem_rd_addr), 256'(exp_maddr));
                check({nm, ":err_cleared"}, 256'(err), 256'(0));
            end
            if (da_wen) begin
                wen_n++;
                wen_c   = c;
                line    = da_wdata;
                waddr   = da_waddr;
                err_wen = err;
            end
            if (done) begin
                done_c   = c;
                err_done = err;
            end
            if (fwd_valid) begin
                fwd_n++;
                fwd_c = c;
                fwd_d = fwd_data;
            end
            if (req_ready && c > 1) begin
                back_c = c;
                break;
            end
            mem_rd_req_ready = (c > req_stall);
            mem_rdata_valid  = (b < 8) && (!gap || (c % 2 == 0));
            mem_rdata        = base + 32'(b);
            mem_rdata_last   = (b == last_idx);
            if (mem_rdata_ready && mem_rdata_valid) begin
                if (b == rst_beat) begin
                    rst     = 1'b1;
                    did_rst = 1'b1;
                end
                b++;
            end
        end
        mem_rd_req_ready = 1'b0;
        mem_rdata_valid  = 1'b0;
        mem_rdata_last   = 1'b0;

        if (rst_beat >= 0) begin
            check({nm, ":idle_after_rst_cycle"}, 256'(back_c), 256'(exp_end));
            check({nm, ":req_ready_after_rst"}, 256'(rdy_after_rst), 256'(1));
            check({nm, ":rdata_ready_after_rst"}, 256'(mrdy_after_rst), 256'(0));
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (da_wen) wen_n++;
            end
            check({nm, ":no_wen"}, 256'(wen_n), 256'(0));
        end else begin
            for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = base + 32'(i);
            wsel = addr[4:2];
            check({nm, ":ready_again_cycle"}, 256'(back_c), 256'(exp_end + 2));
            check({nm, ":wen_count"}, 256'(wen_n), 256'(1));
            check({nm, ":wen_cycle"}, 256'(wen_c), 256'(exp_end));
            check({nm, ":done_cycle"}, 256'(done_c), 256'(exp_end + 1));
            check({nm, ":waddr"}, 256'(waddr), 256'(exp_idx));
            check({nm, ":wdata"}, line, exp_line);
            check({nm, ":err_at_wen"}, 256'(err_wen), 256'(exp_err));
            check({nm, ":err_at_done"}, 256'(err_done), 256'(exp_err));
`ifdef REFILL_FWD_EN
            check({nm, ":fwd_count"}, 256'(fwd_n), 256'(1));
            check({nm, ":fwd_cycle"}, 256'(fwd_c), 256'(exp_fwd));
            check({nm, ":fwd_data"}, 256'(fwd_d), 256'(base + 32'(wsel)));
`else
            check({nm, ":fwd_count"}, 256'(fwd_n), 256'(0));
`endif
        end
    endtask

    initial begin
        rst              = 1'b1;
        req_valid        = 1'b0;
        req_addr         = '0;
        mem_rd_req_ready = 1'b0;
        mem_rdata_valid  = 1'b0;
        mem_rdata        = '0;
        mem_rdata_last   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle:req_ready", 256'(req_ready), 256'(1));
            check("idle:outputs", {mem_rd_req_valid, mem_rdata_ready, da_wen, done, err,
                                   fwd_valid, da_waddr, mem_rd_addr, fwd_data}, '0);
        end
        check("idle:rd_len", 256'(mem_rd_len), 256'(7));

        // name, addr, data base, req stall, gap, last beat, rst beat, end cycle, index, line addr, err, fwd cycle
        run_refill("clean",   32'h0000_1234, 32'h0000_0100, 0, 1'b0, 7, -1, 10, 3'd1, 32'h0000_1220, 1'b0, 8);
        run_refill("stalled", 32'h0000_1234, 32'h0000_0100, 3, 1'b1, 7, -1, 21, 3'd1, 32'h0000_1220, 1'b0, 17);
        run_refill("badlast", 32'h0000_1234, 32'h0000_0100, 0, 1'b0, 5, -1, 10, 3'd1, 32'h0000_1220, 1'b1, 8);
        run_refill("midrst",  32'h0000_1234, 32'h0000_0100, 0, 1'b0, 7,  4,  7, 3'd1, 32'h0000_1220, 1'b0, 0);
        run_refill("after",   32'h0000_00E8, 32'hA000_0000, 0, 1'b0, 7, -1, 10, 3'd7, 32'h0000_00E0, 1'b0, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
